// File: rtl/maze_pkg.sv
// maze_pkg: shared state encoding and size defaults for the maze solver memory path
package maze_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  localparam int AW_DEF        = 8;
  localparam int DW_DEF        = 1;
  localparam int MAX_BURST_DEF = 15;
endpackage

// File: rtl/maze_rr_pick.sv
// maze_rr_pick: 2-way round-robin pick; a tie goes to the requester that did not own last
module maze_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic valid,
  output logic winner
);
  assign valid  = req0 | req1;
  assign winner = (req0 & req1) ? ~last_owner : req1;
endmodule

// File: rtl/maze_mem_arbiter.sv
// maze_mem_arbiter: two-requester arbiter onto a single-port synchronous-read maze cell memory
module maze_mem_arbiter
  import maze_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wd0,
  input  logic [DW-1:0] wd1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic          busy
);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] MAXB = BW'(MAX_BURST);
  state_t state_q, state_d;
  logic owner_q, owner_d, last_q, last_d, we_q, we_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wd_q, wd_d;
  logic in_resp, in_issue, pick_last, pick_valid, pick_winner;
  logic req_own, req_oth, lock_own, cont, arb, src;
  assign in_resp   = state_q == RESP;
  assign in_issue  = state_q == ISSUE;
  // in the ack cycle the current owner counts as last owner already
  assign pick_last = in_resp ? owner_q : last_q;
  maze_rr_pick u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_owner (pick_last),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );
  always_comb begin
    req_own  = owner_q ? req1 : req0;
    req_oth  = owner_q ? req0 : req1;
    lock_own = owner_q ? lock1 : lock0;
    cont     = in_resp & lock_own & req_own & ((burst_q < MAXB) | ~req_oth);
    arb      = ((state_q == IDLE) | (in_resp & ~cont)) & pick_valid;
    src      = cont ? owner_q : pick_winner;
    state_d  = (cont | arb) ? ISSUE : (in_issue ? RESP : IDLE);
    owner_d  = (cont | arb) ? src : owner_q;
    last_d   = in_resp ? owner_q : last_q;
    we_d     = (cont | arb) ? (src ? we1 : we0) : we_q;
    addr_d   = (cont | arb) ? (src ? addr1 : addr0) : addr_q;
    wd_d     = (cont | arb) ? (src ? wd1 : wd0) : wd_q;
    burst_d  = arb ? BW'(1) : (cont ? ((burst_q == MAXB) ? burst_q : burst_q + BW'(1)) : burst_q);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      burst_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
    end
  end
  assign busy     = state_q != IDLE;
  assign gnt0     = busy & ~owner_q;
  assign gnt1     = busy & owner_q;
  assign ack0     = in_resp & ~owner_q;
  assign ack1     = in_resp & owner_q;
  assign rdata    = in_resp ? mem_dout : '0;
  assign mem_en   = in_issue;
  assign mem_wr   = in_issue & we_q;
  assign mem_addr = in_issue ? addr_q : '0;
  assign mem_din  = in_issue ? wd_q : '0;
endmodule

// File: tb/tb_maze_mem_arbiter.sv
// tb_maze_mem_arbiter: directed checks of arbitration, burst locking, memory strobes and reset abort
module tb_maze_mem_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic req0 = 0, req1 = 0, lock0 = 0, lock1 = 0, we0 = 0, we1 = 0;
  logic [7:0] addr0 = 0, addr1 = 0;
  logic wd0 = 0, wd1 = 0;
  logic gnt0, gnt1, ack0, ack1, rdata, mem_en, mem_wr, mem_din, busy;
  logic [7:0] mem_addr;
  logic mem_dout = 1'b0;
  logic mem [256];
  int n_chk = 0, n_fail = 0;
  int n0, n1, ng0;

  always #5 clk = ~clk;

  maze_mem_arbiter dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1), .wd0(wd0), .wd1(wd1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1), .rdata(rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .busy(busy)
  );

  always @(posedge clk) if (mem_en) begin
    if (mem_wr) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset;
    {req0, req1, lock0, lock1, we0, we1, wd0, wd1} = '0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 1'b0;
    mem[8'h12] = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_gnt", {gnt0, gnt1}, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_ack", {ack0, ack1}, 0);
    do_reset;
    // single read of a visited cell
    req0 = 1; addr0 = 8'h12;
    check("rd_c0_busy", busy, 0);
    @(negedge clk);
    check("rd_c1_en", mem_en, 1);
    check("rd_c1_addr", mem_addr, 8'h12);
    check("rd_c1_wr", mem_wr, 0);
    check("rd_c1_gnt0", gnt0, 1);
    check("rd_c1_ack0", ack0, 0);
    @(negedge clk);
    check("rd_c2_ack0", ack0, 1);
    check("rd_c2_rdata", rdata, 1);
    check("rd_c2_gnt0", gnt0, 1);
    check("rd_c2_en", mem_en, 0);
    req0 = 0;
    @(negedge clk);
    check("rd_c3_busy", busy, 0);
    check("rd_c3_rdata", rdata, 0);
    // tie without lock alternates
    do_reset;
    req0 = 1; req1 = 1;
    for (int c = 0; c <= 6; c++) begin
      check($sformatf("alt_ack0_c%0d", c), ack0, (c == 2 || c == 6));
      check($sformatf("alt_ack1_c%0d", c), ack1, (c == 4));
      check($sformatf("alt_excl_c%0d", c), gnt0 & gnt1, 0);
      if (c == 6) begin req0 = 0; req1 = 0; end
      @(negedge clk);
    end
    // locked burst of req0 is cut at MAX_BURST for a waiting req1
    do_reset;
    lock0 = 1; req0 = 1; req1 = 1;
    n0 = 0; n1 = 0;
    for (int c = 0; c <= 32; c++) begin
      if (c < 32) begin n0 += int'(ack0); n1 += int'(ack1); end
      else begin
        check("burst_ack1_slot16", ack1, 1);
        check("burst_gnt1_slot16", gnt1, 1);
        check("burst_ack0_slot16", ack0, 0);
        {lock0, req0, req1} = '0;
      end
      @(negedge clk);
    end
    check("burst_n_ack0", n0, 15);
    check("burst_n_ack1_early", n1, 0);
    // lock with no contender runs on, counter saturates
    do_reset;
    lock1 = 1; req1 = 1;
    n1 = 0; ng0 = 0;
    for (int c = 0; c <= 40; c++) begin
      n1 += int'(ack1);
      ng0 += int'(gnt0);
      if (c == 40) begin
        check("sat_burst_cnt", dut.burst_q, 15);
        lock1 = 0; req1 = 0;
      end
      @(negedge clk);
    end
    check("sat_n_ack1", n1, 20);
    check("sat_gnt0_never", ng0, 0);
    @(negedge clk);
    // write then read back through the ack-cycle re-request
    req1 = 1; we1 = 1; addr1 = 8'hFF; wd1 = 1;
    @(negedge clk);
    check("wr_c1_en", mem_en, 1);
    check("wr_c1_wr", mem_wr, 1);
    check("wr_c1_addr", mem_addr, 8'hFF);
    check("wr_c1_din", mem_din, 1);
    check("wr_c1_gnt1", gnt1, 1);
    @(negedge clk);
    check("wr_c2_ack1", ack1, 1);
    check("wr_c2_wr", mem_wr, 0);
    we1 = 0; wd1 = 0;
    @(negedge clk);
    check("rb_c3_en", mem_en, 1);
    check("rb_c3_wr", mem_wr, 0);
    check("rb_c3_addr", mem_addr, 8'hFF);
    @(negedge clk);
    check("rb_c4_ack1", ack1, 1);
    check("rb_c4_rdata", rdata, 1);
    req1 = 0;
    @(negedge clk);
    // reset in ISSUE aborts immediately
    do_reset;
    req0 = 1; addr0 = 8'h12;
    @(negedge clk);
    check("ab_pre_en", mem_en, 1);
    rst = 1;
    #1;
    check("ab_en", mem_en, 0);
    check("ab_gnt0", gnt0, 0);
    check("ab_busy", busy, 0);
    check("ab_ack", {ack0, ack1}, 0);
    @(negedge clk);
    check("ab_hold_ack", {ack0, ack1}, 0);
    rst = 0; req0 = 1; req1 = 1;
    for (int c = 0; c <= 2; c++) begin
      check($sformatf("ab_tie_ack0_c%0d", c), ack0, (c == 2));
      check($sformatf("ab_tie_ack1_c%0d", c), ack1, 0);
      @(negedge clk);
    end
    req0 = 0; req1 = 0;
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
